// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants and types: block geometry, padder state encoding
// and the 512-bit block type handed from the padder to the sequencer.
package sha1_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_HI_IDX  = 14;
  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_EMIT
  } pad_state_e;

  typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

endpackage

// File: rtl/sha1_last_word_pad.sv
// Combinational shaping of the final message word: keeps the valid leading
// bytes, drops the 0x80 marker into the first invalid byte and zeroes the rest.
module sha1_last_word_pad
  import sha1_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        bytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  // bytes_i == 0 means all four bytes are valid, so the marker spills into the next word
  always_comb begin
    word_o = data_i;
    case (bytes_i)
      2'd1:    word_o = {data_i[31:24], 8'h80, 16'h0000};
      2'd2:    word_o = {data_i[31:16], 8'h80, 8'h00};
      2'd3:    word_o = {data_i[31:8], 8'h80};
      default: word_o = data_i;
    endcase
  end

  assign full_o = (bytes_i == 2'd0);

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: collects big-endian message words into 512-bit
// blocks, appends the 0x80 marker, zero fill and the 64-bit bit length,
// and presents each finished block on a valid/ready handshake.
module sha1_padder
  import sha1_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       msg_data_i,
  input  logic              msg_valid_i,
  input  logic              msg_last_i,
  input  logic [1:0]        msg_bytes_i,
  output logic              msg_ready_o,
  output logic [15:0][31:0] block_o,
  output logic              block_valid_o,
  output logic              block_last_o,
  input  logic              block_ready_i
);

  localparam logic [3:0] IDX_LEN_PREV = 4'(LEN_HI_IDX - 1);
  localparam logic [3:0] IDX_TOP      = 4'(BLOCK_WORDS - 1);

  pad_state_e  state_q;
  logic [3:0]  idx_q;
  logic [60:0] byte_cnt_q;
  logic        pad_pending_q;
  logic        final_q;
  logic        padding_q;   // last word taken, length not yet written
  block_t      buf_q;

  logic [WORD_W-1:0] last_word;
  logic              last_full;
  logic [2:0]        word_bytes_d;
  logic [60:0]       byte_cnt_d;
  logic [3:0]        idx_d;
  logic [63:0]       len_d;

  sha1_last_word_pad u_last_word_pad (
    .data_i  (msg_data_i),
    .bytes_i (msg_bytes_i),
    .word_o  (last_word),
    .full_o  (last_full)
  );

  // Byte contribution of the current word, running count and length field
  always_comb begin
    word_bytes_d = 3'd4;
    if (msg_last_i && (msg_bytes_i != 2'd0)) begin
      word_bytes_d = {1'b0, msg_bytes_i};
    end
    byte_cnt_d = byte_cnt_q + {58'd0, word_bytes_d};
    idx_d      = idx_q + 4'd1;
    len_d      = {byte_cnt_q, 3'b000};
  end

  // Padder FSM with its slot index, byte counter and block buffer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_FILL;
      idx_q         <= 4'd0;
      byte_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      padding_q     <= 1'b0;
      buf_q         <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (msg_valid_i) begin
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            if (msg_last_i) begin
              buf_q[idx_q]  <= last_word;
              pad_pending_q <= last_full;
              padding_q     <= 1'b1;
              if ((idx_q == IDX_LEN_PREV) && !last_full) begin
                state_q <= ST_LEN;
              end else if (idx_q == IDX_TOP) begin
                final_q <= 1'b0;
                state_q <= ST_EMIT;
              end else begin
                state_q <= ST_PAD;
              end
            end else begin
              buf_q[idx_q] <= msg_data_i;
              if (idx_q == IDX_TOP) begin
                final_q       <= 1'b0;
                pad_pending_q <= 1'b0;
                state_q       <= ST_EMIT;
              end
            end
          end
        end
        ST_PAD: begin
          buf_q[idx_q]  <= pad_pending_q ? PAD_WORD : '0;
          pad_pending_q <= 1'b0;
          idx_q         <= idx_d;
          if (idx_q == IDX_LEN_PREV) begin
            state_q <= ST_LEN;
          end else if (idx_q == IDX_TOP) begin
            final_q <= 1'b0;
            state_q <= ST_EMIT;
          end
        end
        ST_LEN: begin
          buf_q[LEN_HI_IDX]     <= len_d[63:32];
          buf_q[LEN_HI_IDX + 1] <= len_d[31:0];
          final_q               <= 1'b1;
          padding_q             <= 1'b0;
          state_q               <= ST_EMIT;
        end
        default: begin
          if (block_ready_i) begin
            idx_q <= 4'd0;
            if (final_q) begin
              byte_cnt_q <= '0;
              final_q    <= 1'b0;
              state_q    <= ST_FILL;
            end else if (padding_q) begin
              state_q <= ST_PAD;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
      endcase
    end
  end

  assign msg_ready_o   = (state_q == ST_FILL);
  assign block_valid_o = (state_q == ST_EMIT);
  assign block_last_o  = (state_q == ST_EMIT) && final_q;
  assign block_o       = buf_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: directed scenarios plus random messages compared
// against a byte-level FIPS 180-4 padding model.
module tb_sha1_padder;
  import sha1_pkg::*;

  localparam int BOUND = 400;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] msg_data_i = '0;
  logic        msg_valid_i = 1'b0;
  logic        msg_last_i = 1'b0;
  logic [1:0]  msg_bytes_i = '0;
  logic        msg_ready_o;
  block_t      block_o;
  logic        block_valid_o;
  logic        block_last_o;
  logic        block_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  bit [7:0]    msg_q[$];
  block_t      exp_blk[$];
  bit          exp_last[$];
  logic [31:0] tail_fill = 32'hDEAD_BEEF;

  sha1_padder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .msg_data_i    (msg_data_i),
    .msg_valid_i   (msg_valid_i),
    .msg_last_i    (msg_last_i),
    .msg_bytes_i   (msg_bytes_i),
    .msg_ready_o   (msg_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_last_o  (block_last_o),
    .block_ready_i (block_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference: append 0x80, zero fill to 56 mod 64, 64-bit bit length, cut into blocks
  function automatic void build_expected();
    bit [7:0] p[$];
    bit [63:0] bits;
    block_t b;
    int nblk;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_blk.delete();
    exp_last.delete();
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      for (int w = 0; w < 16; w++) begin
        b[w] = {p[64*k+4*w], p[64*k+4*w+1], p[64*k+4*w+2], p[64*k+4*w+3]};
      end
      exp_blk.push_back(b);
      exp_last.push_back(k == nblk - 1);
    end
  endfunction

  task automatic set_random_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Streams msg_q as words; must be called at a negedge, returns at a negedge
  task automatic drive_msg(output bit to);
    int n;
    int nw;
    int cnt;
    logic [31:0] d;
    n  = msg_q.size();
    nw = (n + 3) / 4;
    to = 1'b0;
    for (int w = 0; w < nw; w++) begin
      d = tail_fill;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < n) d[31-8*b -: 8] = msg_q[4*w+b];
      end
      msg_data_i  = d;
      msg_last_i  = (w == nw - 1);
      msg_bytes_i = (w == nw - 1) ? 2'(n % 4) : 2'($urandom);
      msg_valid_i = 1'b1;
      cnt = 0;
      while (!msg_ready_o && cnt < BOUND) begin
        @(negedge clk_i);
        cnt++;
      end
      if (!msg_ready_o) begin
        to = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    msg_data_i  = $urandom;
  endtask

  // Waits for a block, captures it, holds ready low 'hold' cycles, then accepts it
  task automatic collect_block(input int hold, output block_t blk, output bit last,
                               output int lat, output bit to);
    lat = 0;
    while (!block_valid_o && lat < BOUND) begin
      @(negedge clk_i);
      lat++;
    end
    to   = !block_valid_o;
    blk  = block_o;
    last = block_last_o;
    repeat (hold) @(negedge clk_i);
    block_ready_i = 1'b1;
    @(negedge clk_i);
    block_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (msg_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", msg_ready_o); end
    checks++; if (block_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", block_valid_o); end
    checks++; if (block_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", block_last_o); end
    checks++; if (block_o !== '0) begin errors++; $display("FAIL reset_block got %h want 0", block_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_abc();
    bit to, cto, last;
    int lat;
    block_t blk;
    msg_q = '{8'h61, 8'h62, 8'h63};
    tail_fill = 32'h0000_00FF;
    drive_msg(to);
    collect_block(0, blk, last, lat, cto);
    checks++; if (to || cto) begin errors++; $display("FAIL abc_timeout got %b%b want 00", to, cto); end
    checks++; if (lat !== 14) begin errors++; $display("FAIL abc_latency got %0d want 14", lat); end
    checks++; if (blk[0] !== 32'h6162_6380) begin errors++; $display("FAIL abc_word0 got %h want 61626380", blk[0]); end
    checks++; if (blk[14:1] !== '0) begin errors++; $display("FAIL abc_zero_fill got %h want 0", blk[14:1]); end
    checks++; if (blk[15] !== 32'h0000_0018) begin errors++; $display("FAIL abc_len got %h want 00000018", blk[15]); end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL abc_last got %b want 1", last); end
  endtask

  task automatic test_56_bytes();
    bit to, cto, last;
    int lat;
    block_t blk;
    set_random_msg(56);
    build_expected();
    drive_msg(to);
    collect_block(0, blk, last, lat, cto);
    checks++; if (to || cto) begin errors++; $display("FAIL b56_timeout got %b%b want 00", to, cto); end
    checks++; if (blk !== exp_blk[0]) begin errors++; $display("FAIL b56_blockA got %h want %h", blk, exp_blk[0]); end
    checks++; if (blk[14] !== PAD_WORD || blk[15] !== 32'h0) begin errors++; $display("FAIL b56_marker got %h_%h want 80000000_00000000", blk[14], blk[15]); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL b56_lastA got %b want 0", last); end
    collect_block(0, blk, last, lat, cto);
    checks++; if (lat !== 15 || cto) begin errors++; $display("FAIL b56_latB got %0d want 15", lat); end
    checks++; if (blk !== exp_blk[1]) begin errors++; $display("FAIL b56_blockB got %h want %h", blk, exp_blk[1]); end
    checks++; if (blk[15] !== 32'h0000_01C0) begin errors++; $display("FAIL b56_len got %h want 000001c0", blk[15]); end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL b56_lastB got %b want 1", last); end
  endtask

  task automatic test_64_bytes();
    bit to, cto, last;
    int lat;
    block_t blk;
    set_random_msg(64);
    build_expected();
    drive_msg(to);
    checks++; if (to || block_valid_o !== 1'b1) begin errors++; $display("FAIL b64_valid_T1 got %b want 1", block_valid_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (msg_ready_o !== 1'b0) begin errors++; $display("FAIL b64_ready_hold got %b want 0", msg_ready_o); end
      @(negedge clk_i);
    end
    collect_block(0, blk, last, lat, cto);
    checks++; if (blk !== exp_blk[0] || last !== 1'b0) begin errors++; $display("FAIL b64_blockA got %h/%b want %h/0", blk, last, exp_blk[0]); end
    collect_block(1, blk, last, lat, cto);
    checks++; if (cto) begin errors++; $display("FAIL b64_timeout got 1 want 0"); end
    checks++; if (blk[0] !== PAD_WORD || blk[15] !== 32'h0000_0200) begin errors++; $display("FAIL b64_blockB_ends got %h_%h want 80000000_00000200", blk[0], blk[15]); end
    checks++; if (blk !== exp_blk[1] || last !== 1'b1) begin errors++; $display("FAIL b64_blockB got %h/%b want %h/1", blk, last, exp_blk[1]); end
  endtask

  task automatic test_53_bytes();
    bit to, cto, last;
    int lat;
    block_t blk;
    set_random_msg(52);
    msg_q.push_back(8'hAA);
    tail_fill = 32'hAABB_CCDD;
    build_expected();
    drive_msg(to);
    collect_block(0, blk, last, lat, cto);
    checks++; if (to || cto) begin errors++; $display("FAIL b53_timeout got %b%b want 00", to, cto); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL b53_latency got %0d want 1", lat); end
    checks++; if (blk[13] !== 32'hAA80_0000) begin errors++; $display("FAIL b53_word13 got %h want aa800000", blk[13]); end
    checks++; if (blk[15] !== 32'h0000_01A8 || blk[14] !== 32'h0) begin errors++; $display("FAIL b53_len got %h_%h want 00000000_000001a8", blk[14], blk[15]); end
    checks++; if (blk !== exp_blk[0] || last !== 1'b1) begin errors++; $display("FAIL b53_block got %h/%b want %h/1", blk, last, exp_blk[0]); end
  endtask

  task automatic test_backpressure();
    bit to1, to2, cto, last;
    int lat;
    block_t blk, snap, exp1;
    set_random_msg(10);
    tail_fill = $urandom;
    build_expected();
    exp1 = exp_blk[0];
    drive_msg(to1);
    set_random_msg(30);
    build_expected();
    fork
      drive_msg(to2);
      begin
        lat = 0;
        while (!block_valid_o && lat < BOUND) begin
          @(negedge clk_i);
          lat++;
        end
        snap = block_o;
        for (int i = 0; i < 20; i++) begin
          checks++;
          if (block_o !== snap || msg_ready_o !== 1'b0 || block_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_hold cycle %0d got %h/%b/%b want %h/0/1", i, block_o, msg_ready_o, block_valid_o, snap);
          end
          @(negedge clk_i);
        end
        collect_block(0, blk, last, lat, cto);
        checks++; if (blk !== exp1 || last !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b want %h/1", blk, last, exp1); end
        collect_block(0, blk, last, lat, cto);
        checks++; if (cto || blk !== exp_blk[0] || last !== 1'b1) begin errors++; $display("FAIL bp_next got %h/%b want %h/1", blk, last, exp_blk[0]); end
      end
    join
    checks++; if (to1 || to2) begin errors++; $display("FAIL bp_drive_timeout got %b%b want 00", to1, to2); end
  endtask

  task automatic test_reset_mid();
    bit to, cto, last;
    int lat;
    block_t blk;
    msg_q = '{8'h61, 8'h62, 8'h63};
    drive_msg(to);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (msg_ready_o !== 1'b1 || block_valid_o !== 1'b0 || block_last_o !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got %b%b%b want 100", msg_ready_o, block_valid_o, block_last_o);
    end
    checks++; if (block_o !== '0) begin errors++; $display("FAIL midrst_block got %h want 0", block_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    drive_msg(to);
    collect_block(0, blk, last, lat, cto);
    checks++; if (to || cto || lat !== 14) begin errors++; $display("FAIL midrst_latency got %0d want 14", lat); end
    checks++; if (blk[0] !== 32'h6162_6380 || blk[15] !== 32'h0000_0018 || blk[14:1] !== '0) begin
      errors++; $display("FAIL midrst_block_after got %h want abc block", blk);
    end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL midrst_last got %b want 1", last); end
  endtask

  task automatic test_random();
    bit to, cto, last;
    int lat;
    block_t blk;
    for (int m = 0; m < 15; m++) begin
      set_random_msg($urandom_range(1, 160));
      tail_fill = $urandom;
      build_expected();
      fork
        drive_msg(to);
        begin
          for (int k = 0; k < exp_blk.size(); k++) begin
            collect_block($urandom_range(0, 4), blk, last, lat, cto);
            checks++;
            if (cto || blk !== exp_blk[k] || last !== exp_last[k]) begin
              errors++; $display("FAIL rand_msg%0d_blk%0d len %0d got %h/%b want %h/%b", m, k, msg_q.size(), blk, last, exp_blk[k], exp_last[k]);
            end
          end
        end
      join
      checks++; if (to || msg_ready_o !== 1'b1) begin errors++; $display("FAIL rand_msg%0d_idle got %b/%b want 0/1", m, to, msg_ready_o); end
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_abc();
    test_56_bytes();
    test_64_bytes();
    test_53_bytes();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
